// File: rtl/scan_pkg.sv
// Shared encodings and the single-advance rule for the scan index sequencer.
package scan_pkg;

    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10
    } mode_e;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUN     = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             dir;
        logic             tc;
    } adv_t;

    // Mode 11 falls into the default branch and behaves as up.
    function automatic adv_t next_adv(
        input logic [1:0]       mode,
        input logic [IDX_W-1:0] idx,
        input logic             dir,
        input logic [IDX_W-1:0] lim
    );
        adv_t r;
        r.idx = idx;
        r.dir = dir;
        r.tc  = 1'b0;
        case (mode)
            MODE_DOWN: begin
                r.dir = 1'b1;
                if (idx == '0) begin
                    r.idx = lim;
                    r.tc  = 1'b1;
                end else begin
                    r.idx = idx - 1'b1;
                end
            end
            MODE_BOUNCE: begin
                if (!dir) begin
                    if (idx >= lim) begin
                        r.dir = 1'b1;
                        r.idx = (lim == '0) ? '0 : lim - 1'b1;
                        r.tc  = 1'b1;
                    end else begin
                        r.idx = idx + 1'b1;
                    end
                end else begin
                    if (idx == '0) begin
                        r.dir = 1'b0;
                        r.idx = (lim == '0) ? '0 : IDX_W'(1);
                        r.tc  = 1'b1;
                    end else begin
                        r.idx = idx - 1'b1;
                    end
                end
            end
            default: begin
                r.dir = 1'b0;
                if (idx >= lim) begin
                    r.idx = '0;
                    r.tc  = 1'b1;
                end else begin
                    r.idx = idx + 1'b1;
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last count as a tick.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/scan_counter.sv
// Registered 4-bit index sequencer feeding a 4-to-16 decoder: run/stop FSM,
// prescaled advance, up/down/bounce walk bounded by a live upper limit.
module scan_counter
    import scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_step,
    input  logic [1:0]       i_mode,
    input  logic             i_load,
    input  logic [IDX_W-1:0] i_load_val,
    input  logic [IDX_W-1:0] i_limit,
    output logic [IDX_W-1:0] o_index,
    output logic             o_tc,
    output logic             o_busy,
    output logic             o_dir
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_index;
    logic             r_dir;
    logic             r_tc;
    logic             w_tick;
    logic             w_adv;
    adv_t             w_res;

    tick_gen #(.DIV(DIV)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (r_state == ST_RUN),
        .i_clr  (i_load || i_start),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_STOPPED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Any control input in a cycle suppresses that cycle's advance.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        if (i_load) begin
            w_state_nxt = r_state;
        end else if (i_stop) begin
            w_state_nxt = ST_STOPPED;
        end else if (i_start) begin
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN) begin
            w_adv = w_tick;
        end else begin
            w_adv = i_step;
        end
    end

    assign w_res = next_adv(i_mode, r_index, r_dir, i_limit);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_index <= '0;
            r_dir   <= 1'b0;
            r_tc    <= 1'b0;
        end else if (i_load) begin
            r_index <= (i_load_val > i_limit) ? i_limit : i_load_val;
            r_tc    <= 1'b0;
        end else if (w_adv) begin
            r_index <= w_res.idx;
            r_dir   <= w_res.dir;
            r_tc    <= w_res.tc;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign o_index = r_index;
    assign o_tc    = r_tc;
    assign o_busy  = (r_state == ST_RUN);
    assign o_dir   = r_dir;

endmodule

// File: tb/tb_scan_counter.sv
// Bench for scan_counter: two instances (DIV=4, DIV=1) against a behavioural model.
module tb_scan_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, step = 1'b0, load = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] load_val = 4'd0, limit = 4'd15;

    logic [3:0] o_index4, o_index1;
    logic       o_tc4, o_tc1, o_busy4, o_busy1, o_dir4, o_dir1;

    int checks = 0;
    int errors = 0;
    int tc_cnt4 = 0;

    int divs [2] = '{4, 1};
    int m_run [2], m_pre [2], m_idx [2], m_dir [2], m_tc [2];

    always #5 clk = ~clk;

    scan_counter #(.DIV(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_step(step),
        .i_mode(mode), .i_load(load), .i_load_val(load_val), .i_limit(limit),
        .o_index(o_index4), .o_tc(o_tc4), .o_busy(o_busy4), .o_dir(o_dir4)
    );

    scan_counter #(.DIV(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_step(step),
        .i_mode(mode), .i_load(load), .i_load_val(load_val), .i_limit(limit),
        .o_index(o_index1), .o_tc(o_tc1), .o_busy(o_busy1), .o_dir(o_dir1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One advance from the rules: direction of travel, then wrap or turn at the ends.
    task automatic ref_advance(input int k);
        int lim, going_up;
        bit bounce;
        lim    = int'(limit);
        bounce = (mode == 2'd2);
        going_up = bounce ? (m_dir[k] == 0) : (mode != 2'd1);
        if (!bounce) m_dir[k] = (mode == 2'd1) ? 1 : 0;
        if (going_up) begin
            if (m_idx[k] >= lim) begin
                m_tc[k] = 1;
                if (bounce) begin
                    m_dir[k] = 1;
                    m_idx[k] = (lim > 0) ? lim - 1 : 0;
                end else begin
                    m_idx[k] = 0;
                end
            end else begin
                m_idx[k] = m_idx[k] + 1;
            end
        end else begin
            if (m_idx[k] == 0) begin
                m_tc[k] = 1;
                if (bounce) begin
                    m_dir[k] = 0;
                    m_idx[k] = (lim > 0) ? 1 : 0;
                end else begin
                    m_idx[k] = lim;
                end
            end else begin
                m_idx[k] = m_idx[k] - 1;
            end
        end
    endtask

    task automatic model_step(input int k);
        bit adv;
        adv = 1'b0;
        if (rst) begin
            m_run[k] = 0; m_pre[k] = 0; m_idx[k] = 0; m_dir[k] = 0; m_tc[k] = 0;
            return;
        end
        m_tc[k] = 0;
        if (load) begin
            m_idx[k] = (load_val > limit) ? int'(limit) : int'(load_val);
            m_pre[k] = 0;
            return;
        end
        if (m_run[k] != 0) begin
            if (stop) begin
                m_run[k] = 0;
            end else if (start) begin
                m_pre[k] = 0;
            end else begin
                adv = (m_pre[k] == divs[k] - 1);
                m_pre[k] = (m_pre[k] + 1) % divs[k];
            end
        end else if (!stop) begin
            if (start) begin
                m_run[k] = 1;
                m_pre[k] = 0;
            end else begin
                adv = step;
            end
        end
        if (adv) ref_advance(k);
    endtask

    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            if (o_tc4 === 1'b1) tc_cnt4++;
            chk("index_div4", 32'(o_index4), m_idx[0]);
            chk("tc_div4",    32'(o_tc4),    m_tc[0]);
            chk("busy_div4",  32'(o_busy4),  m_run[0]);
            chk("dir_div4",   32'(o_dir4),   m_dir[0]);
            chk("index_div1", 32'(o_index1), m_idx[1]);
            chk("tc_div1",    32'(o_tc1),    m_tc[1]);
            chk("busy_div1",  32'(o_busy1),  m_run[1]);
            chk("dir_div1",   32'(o_dir1),   m_dir[1]);
        end
    endtask

    initial begin
        int expv [3] = '{0, 5, 4};

        // Reset
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;

        // Up count through all 16 indices at DIV=4
        mode = 2'd0; limit = 4'd15; start = 1'b1;
        cyc(1);
        start = 1'b0;
        tc_cnt4 = 0;
        cyc(64);
        chk("up_tc_pulses", 32'(tc_cnt4), 1);
        chk("up_wrap_index", 32'(o_index4), 0);

        // Bounce with limit 3
        rst = 1'b1; cyc(1); rst = 1'b0;
        mode = 2'd2; limit = 4'd3; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(12);

        // Load clamped to limit mid-run, then first advance DIV cycles later
        rst = 1'b1; cyc(1); rst = 1'b0;
        mode = 2'd0; limit = 4'd15; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(6);
        limit = 4'd9; load_val = 4'd12; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("load_clamp", 32'(o_index4), 9);
        chk("load_no_tc", 32'(o_tc4), 0);
        cyc(3);
        chk("load_hold", 32'(o_index4), 9);
        cyc(1);
        chk("load_first_adv", 32'(o_index4), 0);
        chk("load_first_tc", 32'(o_tc4), 1);

        // Single-step down while stopped
        stop = 1'b1; cyc(1); stop = 1'b0;
        mode = 2'd1; limit = 4'd5; load_val = 4'd1; load = 1'b1;
        cyc(1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            chk("step_index", 32'(o_index4), expv[i]);
            chk("step_tc", 32'(o_tc4), (expv[i] == 5) ? 1 : 0);
            chk("step_busy", 32'(o_busy4), 0);
            cyc(2);
        end

        // START+STOP together, then RST together with LOAD
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(5);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(o_busy4), 0);
        cyc(3);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(5);
        rst = 1'b1; load = 1'b1; load_val = 4'd7;
        cyc(1);
        rst = 1'b0; load = 1'b0;
        chk("rst_index", 32'(o_index4), 0);
        chk("rst_busy", 32'(o_busy4), 0);
        chk("rst_dir", 32'(o_dir4), 0);

        // Limit 0 in every mode: index parked at 0, TC on every advance
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m); limit = 4'd0; load_val = 4'd0; load = 1'b1;
            cyc(1);
            load = 1'b0; start = 1'b1;
            cyc(1);
            start = 1'b0;
            tc_cnt4 = 0;
            cyc(12);
            chk("lim0_tc_pulses", 32'(tc_cnt4), 3);
            chk("lim0_index", 32'(o_index4), 0);
        end

        // Randomized control traffic
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(63) == 0);
            load  = ($urandom_range(15) == 0);
            start = ($urandom_range(11) == 0);
            stop  = ($urandom_range(15) == 0);
            step  = ($urandom_range(3) == 0);
            load_val = 4'($urandom_range(15));
            if ($urandom_range(7) == 0) limit = 4'($urandom_range(15));
            if ($urandom_range(9) == 0) mode = 2'($urandom_range(3));
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_counter.md
# scan_counter

Registered 4-bit index sequencer that sits directly upstream of the 4-to-16 `DECODER`. `INDEX` drives `DECODER.IN`, so the decoder's one-hot output walks across 16 lines: LED bar, display digit select, or channel scan. The block provides a prescaled advance rate, up/down/bounce sequencing with a programmable upper limit, parallel load, single-step, and a terminal-count pulse.

## Interface
- `DIV`, default 4: clock cycles per automatic advance in RUN. Legal range 1..65535. `DIV`=1 advances every cycle.
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: enter RUN.
- `STOP` in 1: enter STOPPED.
- `STEP` in 1: one advance while STOPPED.
- `MODE` in 2: 00 up, 01 down, 10 bounce, 11 treated as up.
- `LOAD` in 1: parallel load of `LOAD_VAL`.
- `LOAD_VAL` in 4: load value.
- `LIMIT` in 4: highest index visited. Sampled live.
- `INDEX` out 4: current index, to `DECODER.IN`.
- `TC` out 1: one-cycle pulse on wrap or bounce turn.
- `BUSY` out 1: high in RUN.
- `DIR` out 1: 0 up, 1 down. Meaningful in bounce.

## Operation
- FSM has two states.
  - STOPPED: no automatic advance. `STEP` produces exactly one advance.
  - RUN: advances on every prescaler tick.
- Control priority per cycle: `RST` > `LOAD` > `STOP` > `START` > `STEP`.
  - `START`+`STOP` together: STOP wins.
  - `STEP` in RUN is ignored.
- `LOAD`:
  - `INDEX` <= min(`LOAD_VAL`, `LIMIT`).
  - Prescaler cleared. `TC` = 0.
  - FSM state and `DIR` unchanged.
- `START` clears the prescaler, so the first RUN advance occurs `DIV` cycles later.
- Prescaler counts 0..`DIV`-1 only in RUN. The tick fires at `DIV`-1, then the count wraps to 0.
- Advance rules:
  - Up: if `INDEX` >= `LIMIT`, then `INDEX` <= 0 and `TC`. Otherwise `INDEX`+1.
  - Down: if `INDEX` == 0, then `INDEX` <= `LIMIT` and `TC`. Otherwise `INDEX`-1.
  - Bounce, `DIR`=0: if `INDEX` >= `LIMIT`, then `DIR` <= 1, `INDEX` <= `LIMIT`-1 (0 if `LIMIT`=0), and `TC`. Otherwise +1.
  - Bounce, `DIR`=1: if `INDEX` == 0, then `DIR` <= 0, `INDEX` <= 1 (0 if `LIMIT`=0), and `TC`. Otherwise -1.
- `LIMIT`=0: `INDEX` holds at 0 and `TC` pulses on every advance, in all modes.
- `LIMIT` lowered below `INDEX` mid-run:
  - Up and bounce-up: wrap/turn on the next advance.
  - Down: decrements normally.
- `MODE` changes take effect at the next advance.
  - Entering up forces `DIR` <= 0 at that advance.
  - Entering down forces `DIR` <= 1 at that advance.
  - Entering bounce keeps the current `DIR`.
- All arithmetic is 4-bit unsigned. No index ever exceeds 15.

## Timing
- All outputs are registered.
- Reset values: `INDEX`=0, `TC`=0, `BUSY`=0, `DIR`=0. State is STOPPED, prescaler is 0.
- `RST` mid-run returns every register to its reset value on that edge, regardless of other inputs.
- An advance updates `INDEX` on the clock edge after the tick or `STEP` cycle.
- `TC` is high in the same cycle `INDEX` first shows the wrapped/turned value, for exactly one cycle.
- `BUSY` rises the cycle after `START` is sampled and falls the cycle after `STOP` is sampled.
- In RUN with no control activity, `INDEX` changes exactly every `DIV` cycles.
- Downstream decoder adds zero cycles. Its one-hot output follows `INDEX` combinationally.

## Structure
- Package `scan_pkg`: `MODE_UP`, `MODE_DOWN`, `MODE_BOUNCE` encodings; STOPPED/RUN state encoding; index width constant 4.
- Sub-module `tick_gen`:
  - Parameter `DIV`; inputs `CLK`, `RST`, `EN`, `CLR`; output `TICK`.
  - Counter width is clog2(`DIV`), minimum 1.
- Top level holds the FSM, the index/`DIR` registers and the `TC` register.

## Test plan
- Reset, then `START`, `MODE`=00, `LIMIT`=15, `DIV`=4 -> `INDEX` 1,2,…,15,0 at 4-cycle spacing; `TC` single pulse with `INDEX`=0.
- Bounce, `LIMIT`=3, `DIV`=1 -> `INDEX` 0,1,2,3,2,1,0,1; `TC` with the 2 after 3 and with the 1 after 0; `DIR` toggles at each turn.
- `LOAD` with `LOAD_VAL`=12, `LIMIT`=9 mid-run -> `INDEX`=9 next cycle, no `TC`; first advance follows 4 cycles later (`DIV`=4).
- STOPPED, down mode, `LIMIT`=5, three `STEP` pulses from `INDEX`=1 -> 0, 5 (`TC`), 4; `BUSY` stays 0.
- `START` and `STOP` asserted together in RUN -> STOPPED, `BUSY`=0; `RST` asserted with `LOAD` -> all reset values.
- `LIMIT`=0 in RUN, any mode -> `INDEX` stays 0 and `TC` pulses every `DIV` cycles.
